jk_cmd_seq: RTL and testbench

Command sequencer directly upstream of the JK flip-flop stage. Accepts timed JK commands (HOLD/SET/RESET/TOGGLE plus a repeat length) over a valid/ready interface, buffers them in a small FIFO, and drives the 2-bit `state` code into the flip-flop's `state` input one cycle at a time. Between commands it drives HOLD, so the downstream Q stays stable.

---
 rtl/jk_pkg.sv | 16 +
 rtl/jk_cmd_fifo.sv | 56 +++++
 rtl/jk_cmd_seq.sv | 142 ++++++++++++++
 tb/tb_jk_cmd_seq.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/jk_pkg.sv
// Shared op codes and sequencer state encoding for the JK command path.
package jk_pkg;

    typedef logic [1:0] jk_op_t;

    localparam jk_op_t JK_HOLD   = 2'b00;
    localparam jk_op_t JK_SET    = 2'b01;
    localparam jk_op_t JK_RESET  = 2'b10;
    localparam jk_op_t JK_TOGGLE = 2'b11;

    typedef enum logic {
        SEQ_IDLE,
        SEQ_RUN
    } seq_state_t;

endpackage

// File: rtl/jk_cmd_fifo.sv
// Command FIFO: first-word fall-through read, occupancy counter, async reset.
module jk_cmd_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned W     = 6
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] wdata,
    output logic [W-1:0] rdata_c,
    output logic         full_c,
    output logic         empty_c
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;

    assign rdata_c = mem[rd_ptr];
    assign full_c  = (count == CW'(DEPTH));
    assign empty_c = (count == '0);

    // Storage carries no reset; only the pointers and count define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/jk_cmd_seq.sv
// JK command sequencer: queues timed ops and plays them onto the JK state input.
// Optional Q shadow checker enabled by defining JK_CMD_SEQ_SHADOW_EN.
module jk_cmd_seq
    import jk_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned LEN_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [LEN_W-1:0] cmd_len,
    output logic [1:0]       state,
    output logic             busy,
    output logic             cmd_done
`ifdef JK_CMD_SEQ_SHADOW_EN
    ,
    output logic             q_model,
    input  logic             q_obs,
    output logic             q_err
`endif
);

    localparam int unsigned DW = 2 + LEN_W;

    seq_state_t       fsm_q;
    seq_state_t       fsm_d;
    jk_op_t           state_d;
    logic [LEN_W-1:0] rem_q;
    logic [LEN_W-1:0] rem_d;
    logic             busy_d;
    logic             done_d;
    logic             push;
    logic             pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic [DW-1:0]    head;
    jk_op_t           head_op;
    logic [LEN_W-1:0] head_len;

    assign cmd_ready = !fifo_full;
    assign push      = cmd_valid && cmd_ready;
    assign head_op   = jk_op_t'(head[DW-1 -: 2]);
    assign head_len  = head[LEN_W-1:0];

    jk_cmd_fifo #(
        .DEPTH (DEPTH),
        .W     (DW)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (push),
        .pop     (pop),
        .wdata   ({cmd_op, cmd_len}),
        .rdata_c (head),
        .full_c  (fifo_full),
        .empty_c (fifo_empty)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm_q    <= SEQ_IDLE;
            state    <= JK_HOLD;
            rem_q    <= '0;
            busy     <= 1'b0;
            cmd_done <= 1'b0;
        end else begin
            fsm_q    <= fsm_d;
            state    <= state_d;
            rem_q    <= rem_d;
            busy     <= busy_d;
            cmd_done <= done_d;
        end
    end

    // Next command is popped on the edge that ends the last cycle, so no HOLD gap.
    always_comb begin
        fsm_d   = fsm_q;
        state_d = jk_op_t'(state);
        rem_d   = rem_q;
        busy_d  = busy;
        done_d  = 1'b0;
        pop     = 1'b0;
        case (fsm_q)
            SEQ_IDLE: begin
                state_d = JK_HOLD;
                busy_d  = 1'b0;
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    state_d = head_op;
                    rem_d   = head_len;
                    busy_d  = 1'b1;
                    done_d  = (head_len == '0);
                    fsm_d   = SEQ_RUN;
                end
            end
            SEQ_RUN: begin
                if (rem_q != '0) begin
                    rem_d  = rem_q - LEN_W'(1);
                    done_d = (rem_q == LEN_W'(1));
                end else if (!fifo_empty) begin
                    pop     = 1'b1;
                    state_d = head_op;
                    rem_d   = head_len;
                    done_d  = (head_len == '0);
                end else begin
                    state_d = JK_HOLD;
                    busy_d  = 1'b0;
                    fsm_d   = SEQ_IDLE;
                end
            end
            default: begin
                state_d = JK_HOLD;
                busy_d  = 1'b0;
                fsm_d   = SEQ_IDLE;
            end
        endcase
    end

`ifdef JK_CMD_SEQ_SHADOW_EN
    // Shadow of downstream Q, advanced with the op currently driven on state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_model <= 1'b0;
            q_err   <= 1'b0;
        end else begin
            case (jk_op_t'(state))
                JK_SET:    q_model <= 1'b1;
                JK_RESET:  q_model <= 1'b0;
                JK_TOGGLE: q_model <= !q_model;
                default:   q_model <= q_model;
            endcase
            if (q_obs != q_model) begin
                q_err <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_jk_cmd_seq.sv
// Bench for jk_cmd_seq: directed vector table, corner sequences and random traffic
// against a command-stream reference model.
module tb_jk_cmd_seq;

    localparam int DEPTH = 4;
    localparam int LEN_W = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             cmd_valid = 1'b0;
    logic             cmd_ready;
    logic [1:0]       cmd_op = 2'b00;
    logic [LEN_W-1:0] cmd_len = '0;
    logic [1:0]       state;
    logic             busy;
    logic             cmd_done;
    logic             q_obs = 1'b0;
`ifdef JK_CMD_SEQ_SHADOW_EN
    logic             q_model;
    logic             q_err;
`endif

    always #5 clk = ~clk;

    jk_cmd_seq #(.DEPTH(DEPTH), .LEN_W(LEN_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_len   (cmd_len),
        .state     (state),
        .busy      (busy),
        .cmd_done  (cmd_done)
`ifdef JK_CMD_SEQ_SHADOW_EN
        ,
        .q_model   (q_model),
        .q_obs     (q_obs),
        .q_err     (q_err)
`endif
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: queue of pending commands plus cycles left of the active one.
    typedef struct {
        logic [1:0] op;
        int         len;
    } cmd_t;

    cmd_t       mq[$];
    int         m_left = 0;
    logic [1:0] m_op = 2'b00;
    logic       m_q = 1'b0;
    logic       m_qerr = 1'b0;
    int         n_push = 0;

    typedef struct {
        logic       valid;
        logic [1:0] op;
        logic [3:0] len;
        logic [1:0] e_state;
        logic       e_busy;
        logic       e_done;
        logic       e_ready;
    } vec_t;

    vec_t tbl[11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [1:0] m_state();
        return (m_left > 0) ? m_op : 2'b00;
    endfunction

    task automatic model_reset();
        mq.delete();
        m_left = 0;
        m_op   = 2'b00;
        m_q    = 1'b0;
        m_qerr = 1'b0;
    endtask

    // One clock: advance the model with the inputs as seen at the edge, then compare.
    task automatic step();
        bit         pre_ready;
        logic [1:0] pre_state;
        cmd_t       c;
        pre_ready = (mq.size() < DEPTH);
        pre_state = m_state();
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            if (q_obs != m_q) m_qerr = 1'b1;
            case (pre_state)
                2'b01:   m_q = 1'b1;
                2'b10:   m_q = 1'b0;
                2'b11:   m_q = ~m_q;
                default: m_q = m_q;
            endcase
            if (m_left <= 1 && mq.size() > 0) begin
                c      = mq.pop_front();
                m_op   = c.op;
                m_left = c.len + 1;
            end else if (m_left > 0) begin
                m_left--;
            end
            if (cmd_valid && pre_ready) begin
                c.op  = cmd_op;
                c.len = int'(cmd_len);
                mq.push_back(c);
                n_push++;
            end
        end
        #1;
        chk("model_state", 32'(state), 32'(m_state()));
        chk("model_busy", 32'(busy), 32'(m_left > 0));
        chk("model_done", 32'(cmd_done), 32'(m_left == 1));
        chk("model_ready", 32'(cmd_ready), 32'(mq.size() < DEPTH));
`ifdef JK_CMD_SEQ_SHADOW_EN
        chk("model_q", 32'(q_model), 32'(m_q));
        chk("model_qerr", 32'(q_err), 32'(m_qerr));
`endif
    endtask

    task automatic drive(input logic v, input logic [1:0] op, input int len);
        cmd_valid = v;
        cmd_op    = op;
        cmd_len   = LEN_W'(len);
        q_obs     = m_q;
    endtask

    initial begin
        // SET len0 then TOGGLE len3 / RESET len1 back-to-back
        tbl[0]  = '{1'b1, 2'd1, 4'd0, 2'd0, 1'b0, 1'b0, 1'b1};
        tbl[1]  = '{1'b0, 2'd0, 4'd0, 2'd1, 1'b1, 1'b1, 1'b1};
        tbl[2]  = '{1'b0, 2'd0, 4'd0, 2'd0, 1'b0, 1'b0, 1'b1};
        tbl[3]  = '{1'b1, 2'd3, 4'd3, 2'd0, 1'b0, 1'b0, 1'b1};
        tbl[4]  = '{1'b1, 2'd2, 4'd1, 2'd3, 1'b1, 1'b0, 1'b1};
        tbl[5]  = '{1'b0, 2'd0, 4'd0, 2'd3, 1'b1, 1'b0, 1'b1};
        tbl[6]  = '{1'b0, 2'd0, 4'd0, 2'd3, 1'b1, 1'b0, 1'b1};
        tbl[7]  = '{1'b0, 2'd0, 4'd0, 2'd3, 1'b1, 1'b1, 1'b1};
        tbl[8]  = '{1'b0, 2'd0, 4'd0, 2'd2, 1'b1, 1'b0, 1'b1};
        tbl[9]  = '{1'b0, 2'd0, 4'd0, 2'd2, 1'b1, 1'b1, 1'b1};
        tbl[10] = '{1'b0, 2'd0, 4'd0, 2'd0, 1'b0, 1'b0, 1'b1};

        // Reset values
        rst = 1'b1;
        model_reset();
        step();
        step();
        rst = 1'b0;
        step();
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(cmd_done), 32'd0);
        chk("rst_ready", 32'(cmd_ready), 32'd1);

        for (int i = 0; i < 11; i++) begin
            drive(tbl[i].valid, tbl[i].op, int'(tbl[i].len));
            step();
            chk($sformatf("tbl%0d_state", i), 32'(state), 32'(tbl[i].e_state));
            chk($sformatf("tbl%0d_busy", i), 32'(busy), 32'(tbl[i].e_busy));
            chk($sformatf("tbl%0d_done", i), 32'(cmd_done), 32'(tbl[i].e_done));
            chk($sformatf("tbl%0d_ready", i), 32'(cmd_ready), 32'(tbl[i].e_ready));
        end

        // Full FIFO: valid held high behind a 16-cycle TOGGLE
        n_push = 0;
        for (int i = 1; i <= 18; i++) begin
            if (i == 1) drive(1'b1, 2'b11, 15);
            else drive(1'b1, 2'((i * 3) % 4), i % 3);
            step();
            if (i >= 5 && i <= 17) chk("full_ready_low", 32'(cmd_ready), 32'd0);
            if (i == 18) chk("full_ready_back", 32'(cmd_ready), 32'd1);
        end
        chk("full_push_count", 32'(n_push), 32'd5);
        drive(1'b0, 2'b00, 0);
        for (int i = 0; i < 20; i++) step();
        chk("full_drained_busy", 32'(busy), 32'd0);

        // Push and pop on the same edge at occupancy 2
        drive(1'b1, 2'b01, 2); step();
        drive(1'b1, 2'b10, 0); step();
        drive(1'b1, 2'b11, 0); step();
        drive(1'b0, 2'b00, 0); step();
        chk("pp_x_done", 32'(cmd_done), 32'd1);
        drive(1'b1, 2'b00, 1); step();
        chk("pp_y_state", 32'(state), 32'd2);
        chk("pp_ready", 32'(cmd_ready), 32'd1);
        drive(1'b0, 2'b00, 0); step();
        chk("pp_z_state", 32'(state), 32'd3);
        step();
        chk("pp_w_state", 32'(state), 32'd0);
        chk("pp_w_busy", 32'(busy), 32'd1);
        step();
        chk("pp_w_done", 32'(cmd_done), 32'd1);
        step();
        chk("pp_idle_busy", 32'(busy), 32'd0);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            drive(1'(($urandom % 3) != 0), 2'($urandom), int'($urandom_range(0, 3)));
            step();
        end
        drive(1'b0, 2'b00, 0);
        for (int i = 0; i < 30; i++) step();

`ifdef JK_CMD_SEQ_SHADOW_EN
        // Shadow Q: RESET then TOGGLE len2, then one forced mismatch
        drive(1'b1, 2'b10, 0); step();
        drive(1'b1, 2'b11, 2); step();
        drive(1'b0, 2'b00, 0); step();
        chk("sh_q0", 32'(q_model), 32'd0);
        drive(1'b0, 2'b00, 0); step();
        chk("sh_q1", 32'(q_model), 32'd1);
        drive(1'b0, 2'b00, 0); step();
        chk("sh_q2", 32'(q_model), 32'd0);
        drive(1'b0, 2'b00, 0); step();
        chk("sh_q3", 32'(q_model), 32'd1);
        chk("sh_err_clean", 32'(q_err), 32'd0);
        drive(1'b0, 2'b00, 0);
        q_obs = ~m_q;
        step();
        chk("sh_err_set", 32'(q_err), 32'd1);
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 2'b00, 0);
            step();
        end
        chk("sh_err_sticky", 32'(q_err), 32'd1);
`endif

        // Async reset in the middle of a TOGGLE len7 with two commands queued
        drive(1'b1, 2'b11, 7); step();
        drive(1'b1, 2'b01, 0); step();
        drive(1'b1, 2'b10, 0); step();
        drive(1'b0, 2'b00, 0); step();
        step();
        chk("mid_running", 32'(state), 32'd3);
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        chk("mid_rst_state", 32'(state), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_ready", 32'(cmd_ready), 32'd1);
`ifdef JK_CMD_SEQ_SHADOW_EN
        chk("mid_rst_qerr", 32'(q_err), 32'd0);
`endif
        step();
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            drive(1'b0, 2'b00, 0);
            step();
            chk("post_rst_state", 32'(state), 32'd0);
            chk("post_rst_busy", 32'(busy), 32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
